// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: parametrised TDM / I2S serial transmitter.
// Frames of CHANNELS slots (DATA_W sample bits zero-padded to SLOT_W) are
// accepted through a valid/ready port into a FIFO_DEPTH-frame FIFO and
// shifted out MSB first. All state updates on the falling edge of sclk.
// Optional feature macro: UNDERRUN_REPEAT_EN -- when defined, an empty FIFO
// at a frame boundary re-sends the last popped frame instead of zeros.
//
// Handshake: a frame is transferred on a falling sclk edge where
// s_valid && s_ready. s_ready is high whenever the FIFO is not full and
// does not look ahead at a same-edge pop. s_data must be held while
// s_valid is high and s_ready is low.
module i2s_tdm_tx #(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               sclk,
  input  logic                               aclr,
  input  logic                               fmt,
  input  logic [CHANNELS*DATA_W-1:0]         s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic                               ws,
  output logic                               dout,
  output logic                               frame_start,
  output logic                               underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

  localparam int FRAME = CHANNELS * SLOT_W;
  localparam int HALF  = FRAME / 2;
  localparam int RAW_W = CHANNELS * DATA_W;
  localparam int BC_W  = $clog2(FRAME);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [RAW_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic [BC_W-1:0]  bc_q, bc_d;
  logic [FRAME-1:0] shift_q, next_img;
  logic [RAW_W-1:0] next_raw;
  logic             wrap, push, pop, fmt_eff, ws_d;
  logic             s_q, dly_q, ws_q, fmt_q, fs_q, ur_q;
`ifdef UNDERRUN_REPEAT_EN
  logic [RAW_W-1:0] last_q;
`endif

  // Lay a raw frame out as the serial image: channel 0 in the MSBs, each
  // slot holds its sample left-aligned with zero padding below it.
  function automatic logic [FRAME-1:0] expand(input logic [RAW_W-1:0] raw);
    logic [FRAME-1:0] img;
    img = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      img[FRAME-1-k*SLOT_W -: SLOT_W] =
        SLOT_W'(raw[(CHANNELS-k)*DATA_W-1 -: DATA_W]) << (SLOT_W - DATA_W);
    end
    return img;
  endfunction

  // Next-state decode: bit counter, FIFO handshake, frame source selection.
  always_comb begin
    wrap    = (bc_q == BC_W'(FRAME - 1));
    bc_d    = wrap ? '0 : bc_q + 1'b1;
    s_ready = (level_q != LVL_W'(FIFO_DEPTH));
    push    = s_valid && s_ready;
    pop     = wrap && (level_q != '0);
    // The format sampled at the wrap edge governs the whole new frame.
    fmt_eff = wrap ? fmt : fmt_q;
    ws_d    = (bc_d >= BC_W'(HALF)) ^ fmt_eff;
    level_d = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    if (pop && !push) level_d = level_q - 1'b1;
`ifdef UNDERRUN_REPEAT_EN
    next_raw = pop ? mem_q[rd_ptr_q] : last_q;
`else
    next_raw = pop ? mem_q[rd_ptr_q] : '0;
`endif
    next_img = expand(next_raw);
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(negedge sclk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

`ifdef UNDERRUN_REPEAT_EN
  // Remember the most recently popped frame for replay on underrun.
  always_ff @(negedge sclk or posedge aclr) begin
    if (aclr)     last_q <= '0;
    else if (pop) last_q <= mem_q[rd_ptr_q];
  end
`endif

  // Main datapath: counter, FIFO pointers, shifter and registered outputs.
  always_ff @(negedge sclk or posedge aclr) begin
    if (aclr) begin
      bc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      shift_q  <= '0;
      s_q      <= 1'b0;
      dly_q    <= 1'b0;
      ws_q     <= 1'b0;
      fmt_q    <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      bc_q    <= bc_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wrap) begin
        fmt_q   <= fmt;
        shift_q <= next_img;
        s_q     <= next_img[FRAME-1];
      end else begin
        // s_q always presents the bit for the current bc; the register
        // shifts left so the following bit sits just below the MSB.
        shift_q <= shift_q << 1;
        s_q     <= shift_q[FRAME-2];
      end
      // I2S delays the data by one sclk relative to ws.
      dly_q <= s_q;
      ws_q  <= ws_d;
      fs_q  <= (bc_d == '0);
      ur_q  <= wrap && (level_q == '0);
    end
  end

  assign ws          = ws_q;
  assign dout        = fmt_q ? s_q : dly_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;
  assign level       = level_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb_i2s_tdm_tx: directed bench for i2s_tdm_tx (default 2x24/32 instance
// plus a 4x16/16 left-justified instance sharing clock and reset).
module tb_i2s_tdm_tx;

  // ---------------- clock / reset ----------------
  logic sclk = 1'b1;
  logic aclr = 1'b1;
  always #5 sclk = ~sclk;

  logic        fmt = 1'b0;
  logic [47:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, ws, dout, frame_start, underrun;
  logic [2:0]  level;

  logic        fmt4 = 1'b1;
  logic [63:0] s_data4 = '0;
  logic        s_valid4 = 1'b0;
  logic        s_ready4, ws4, dout4, frame_start4, underrun4;
  logic [2:0]  level4;

  i2s_tdm_tx u_dut (
    .sclk(sclk), .aclr(aclr), .fmt(fmt), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ws(ws), .dout(dout), .frame_start(frame_start),
    .underrun(underrun), .level(level)
  );

  i2s_tdm_tx #(.DATA_W(16), .SLOT_W(16), .CHANNELS(4), .FIFO_DEPTH(4)) u_dut4 (
    .sclk(sclk), .aclr(aclr), .fmt(fmt4), .s_data(s_data4), .s_valid(s_valid4),
    .s_ready(s_ready4), .ws(ws4), .dout(dout4), .frame_start(frame_start4),
    .underrun(underrun4), .level(level4)
  );

  // ---------------- scoreboard ----------------
  logic [47:0] exp_q[$];
  logic [47:0] last_frame = '0;
  logic [47:0] exp_fr;
  int          checks = 0;
  int          failures = 0;
  int          gen_n = 0;
  logic        stream_mode = 1'b0;

  localparam logic [47:0] FR_A = {24'hABCDEF, 24'h123456};
  localparam logic [47:0] FR_P = {24'h800001, 24'h7FFFFF};
  localparam logic [63:0] ONE_HOT0 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] gen(input int n);
    return {24'h5A0000 | 24'(n), 24'hFF00FF ^ 24'(n)};
  endfunction

  // Expected dout over one frame, bc 0 first (MSB). Padding makes the
  // previous frame's last bit 0, so I2S is the LJ image delayed by one.
  function automatic logic [63:0] exp_dout(input logic [47:0] fr, input logic f);
    logic [63:0] img;
    img = {fr[47:24], 8'h00, fr[23:0], 8'h00};
    return f ? img : (img >> 1);
  endfunction

  function automatic logic [47:0] ur_frame();
`ifdef UNDERRUN_REPEAT_EN
    return last_frame;
`else
    return '0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // One falling edge; outputs are then sampled 1ns later.
  task automatic step();
    logic acc;
    acc = s_valid && s_ready;
    @(negedge sclk);
    #1;
    s_valid4 = 1'b0;
    if (acc) begin
      if (stream_mode) begin
        exp_q.push_back(s_data);
        gen_n++;
        s_data = gen(gen_n);
      end else begin
        s_valid = 1'b0;
      end
    end
  endtask

  // Record one whole frame starting at bc=0 and compare it.
  task automatic capture(input logic [47:0] fr, input logic f, input logic ur,
                         input logic [63:0] rdy_exp, input string tag, input logic chk4);
    logic [63:0] dc, wc, fc, uc, rc, d4, w4, f4, u4;
    dc = '0; wc = '0; fc = '0; uc = '0; rc = '0; d4 = '0; w4 = '0; f4 = '0; u4 = '0;
    for (int i = 0; i < 64; i++) begin
      dc = {dc[62:0], dout};
      wc = {wc[62:0], ws};
      fc = {fc[62:0], frame_start};
      uc = {uc[62:0], underrun};
      rc = {rc[62:0], s_ready};
      d4 = {d4[62:0], dout4};
      w4 = {w4[62:0], ws4};
      f4 = {f4[62:0], frame_start4};
      u4 = {u4[62:0], underrun4};
      step();
    end
    check({tag, "_dout"}, dc, exp_dout(fr, f));
    check({tag, "_ws"}, wc, f ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF);
    check({tag, "_fs"}, fc, ONE_HOT0);
    check({tag, "_ur"}, uc, ur ? ONE_HOT0 : 64'h0);
    check({tag, "_rdy"}, rc, rdy_exp);
    if (chk4) begin
      check("ch4_dout", d4, 64'hA5C3_1234_FFFF_8001);
      check("ch4_ws", w4, 64'hFFFF_FFFF_0000_0000);
      check("ch4_fs", f4, ONE_HOT0);
      check("ch4_ur", u4, 64'h0);
    end
    if (!ur) last_frame = fr;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #2;
    check("rst_ws", ws, 0);
    check("rst_dout", dout, 0);
    check("rst_level", level, 0);
    check("rst_ready", s_ready, 1);
    check("rst_fs", frame_start, 0);
    check("rst_ur", underrun, 0);
    check("rst_ready4", s_ready4, 1);
    @(negedge sclk);
    #1;
    aclr = 1'b0;

    // Frame 1 (reset frame): push A and the 4-channel frame on the first edge.
    s_data = FR_A; s_valid = 1'b1;
    s_data4 = {16'hA5C3, 16'h1234, 16'hFFFF, 16'h8001}; s_valid4 = 1'b1;
    step();
    check("push_level", level, 1);
    check("push_level4", level4, 1);
    for (int i = 0; i < 63; i++) step();

    // Frame 2: A in I2S; 4-channel instance sends its frame left-justified.
    capture(FR_A, 1'b0, 1'b0, ALL_ONES, "i2s_a", 1'b1);
    check("drained_level", level, 0);

    // Frame 3: underruns; fmt switched mid-frame, A pushed for next frame.
    fmt = 1'b1;
    s_data = FR_A; s_valid = 1'b1;
    capture(ur_frame(), 1'b0, 1'b1, ALL_ONES, "fmt_hold", 1'b0);

    // Frame 4: A left-justified.
    capture(FR_A, 1'b1, 1'b0, ALL_ONES, "lj_a", 1'b0);

    // Frame 5: underrun in LJ while s_valid is held high to fill the FIFO.
    fmt = 1'b0;
    stream_mode = 1'b1;
    gen_n = 0;
    s_data = gen(0); s_valid = 1'b1;
    capture(ur_frame(), 1'b1, 1'b1, 64'hF000_0000_0000_0000, "fill", 1'b0);

    // Frames 6-15: one accepted push per frame, order preserved.
    for (int f = 0; f < 10; f++) begin
      exp_fr = exp_q.pop_front();
      capture(exp_fr, 1'b0, 1'b0, ONE_HOT0, $sformatf("stream%0d", f), 1'b0);
    end

    // Frames 16-19: drain the remaining four frames.
    s_valid = 1'b0;
    stream_mode = 1'b0;
    for (int f = 0; f < 4; f++) begin
      exp_fr = exp_q.pop_front();
      capture(exp_fr, 1'b0, 1'b0, ALL_ONES, $sformatf("drain%0d", f), 1'b0);
    end
    check("sb_empty", 64'(exp_q.size()), 0);

    // Frame 20: underrun, push the 0x800001/0x7FFFFF frame.
    s_data = FR_P; s_valid = 1'b1;
    capture(ur_frame(), 1'b0, 1'b1, ALL_ONES, "ur20", 1'b0);
    capture(FR_P, 1'b0, 1'b0, ALL_ONES, "pat", 1'b0);
    capture(ur_frame(), 1'b0, 1'b1, ALL_ONES, "ur22", 1'b0);

    // Frame 23: underrun while four frames are loaded.
    stream_mode = 1'b1;
    gen_n++;
    s_data = gen(gen_n); s_valid = 1'b1;
    capture(ur_frame(), 1'b0, 1'b1, 64'hF000_0000_0000_0000, "ur23", 1'b0);
    s_valid = 1'b0;
    stream_mode = 1'b0;

    // Frame 24: run to bc=40 with three frames held, then reset mid-frame.
    for (int i = 0; i < 40; i++) step();
    check("pre_rst_level", level, 3);
    check("pre_rst_ws", ws, 1);
    check("pre_rst_dout", dout, 1);
    aclr = 1'b1;
    #2;
    check("mid_rst_ws", ws, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_ready", s_ready, 1);
    check("mid_rst_fs", frame_start, 0);
    #3;
    aclr = 1'b0;

    // After release: silent frame, then the first wrap underruns.
    for (int i = 0; i < 63; i++) step();
    check("post_rst_dout", dout, 0);
    check("post_rst_ws", ws, 1);
    step();
    check("post_rst_ur", underrun, 1);
    check("post_rst_fs", frame_start, 1);
    check("post_rst_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
Parametrised successor to the team's fixed 2x32-bit I2S transmitter. Serialises frames of CHANNELS slots, each carrying DATA_W bits zero-padded to SLOT_W. Frames arrive through a valid/ready interface into a FIFO_DEPTH-frame FIFO. Supports I2S and left-justified framing, and flags underrun. It sits between the synth voice mixer and the DAC serial pins.

Parameters:
DATA_W, 24, sample bits per channel; requires 1 <= DATA_W <= SLOT_W.
SLOT_W, 32, sclk cycles per channel slot.
CHANNELS, 2, slots per frame; must be even and >= 2.
FIFO_DEPTH, 4, frames buffered; must be a power of 2 and >= 2.

Ports:
sclk  in  1  bit clock; all state updates on the falling edge.
aclr  in  1  reset, asynchronous, active-high.
fmt  in  1  0 = I2S, 1 = left-justified; quasi-static.
s_data  in  CHANNELS*DATA_W  frame; channel 0 in the MSBs and sent first.
s_valid  in  1  frame valid.
s_ready  out  1  FIFO not full.
ws  out  1  word select (LRCK).
dout  out  1  serial data, MSB first.
frame_start  out  1  high for the first sclk of each frame.
underrun  out  1  high for the first sclk of a frame sent with the FIFO empty.
level  out  $clog2(FIFO_DEPTH+1)  frames currently held in the FIFO.

Behaviour:
- FRAME = CHANNELS*SLOT_W. Bit counter bc counts 0..FRAME-1 and wraps to 0.
- Reset (async, any time, including mid-frame):
  - bc=0, ws=0, dout=0, internal stream bit s=0, shift register=0, fmt_q=0 (I2S).
  - FIFO emptied, level=0, s_ready=1, frame_start=0, underrun=0.
  - Transmission resumes from bc=0 after release.
- Upstream is synchronous to the sclk falling edge.
  - Push when s_valid && s_ready on an edge.
  - s_ready = (level != FIFO_DEPTH). It is not pop-aware: when full, a same-edge pop does not enable a push.
- Wrap edge (bc FRAME-1 -> 0):
  - fmt_q <= fmt.
  - If level > 0: pop the oldest frame into the shift register.
  - Else: load all-zero, and underrun=1 for that bc=0 cycle.
  - Push and pop on the same edge: level unchanged.
  - Push into an empty FIFO on the wrap edge is not bypassed: that frame underruns and the pushed frame is sent next frame.
- Shift image:
  - Each slot is DATA_W sample bits followed by SLOT_W-DATA_W zeros.
  - Slot k is sent during bc in [k*SLOT_W, (k+1)*SLOT_W).
- Stream register s:
  - At the wrap edge, s <= frame bit 0 (MSB of channel 0).
  - On other edges, s <= frame bit bc+1.
  - So s always presents bit bc.
- ws is registered with the new bc. With H = FRAME/2:
  - fmt_q=0: ws=0 for bc<H, 1 otherwise.
  - fmt_q=1: ws=1 for bc<H, 0 otherwise.
- dout:
  - fmt_q=1: dout = s, no delay.
  - fmt_q=0: dout <= s registered, so data lags ws by one sclk (I2S).
  - In I2S mode, bc=0 carries the final bit of the previous frame.
- frame_start: registered, 1 exactly when the new bc == 0.
- Latency: a frame pushed into an empty FIFO at least one edge before a wrap edge has its MSB on dout at the following bc=0 (LJ) or bc=1 (I2S).
- fmt changes mid-frame take effect only at the next wrap edge.

Optional Feature:
UNDERRUN_REPEAT_EN
- Defined: a last-frame register holds the most recent popped frame (reset 0). On an empty wrap edge it is re-sent instead of zeros; underrun still pulses.
- Undefined: zeros are sent and the register is not built.

Test Plan:
Defaults, fmt=0 (I2S):
- Push ch0=0xABCDEF, ch1=0x123456 after reset -> ws=0 for bc 0-31, 1 for bc 32-63. dout bits 1-24 = 0xABCDEF MSB first; bits 25-32 = 0; bits 33-56 = 0x123456. frame_start high at bc=0; underrun=0.
- Same frame with fmt=1 -> ws=1 for bc 0-31. dout bits 0-23 = 0xABCDEF and bits 32-55 = 0x123456. fmt toggled mid-frame takes effect only at the next bc=0.
- Hold s_valid=1 continuously -> s_ready drops after 4 pushes (level=4). One push is accepted per frame thereafter; no frame is lost or reordered across 10 frames.
- No pushes after reset -> underrun pulses at every bc=0; dout=0. With UNDERRUN_REPEAT_EN, after one frame 0x800001/0x7FFFFF the pair repeats and underrun pulses each frame.
- CHANNELS=4, DATA_W=16, SLOT_W=16, fmt=1 -> frame is 64 sclk; ws high for bc 0-31; slots emitted in order ch0..ch3.
- aclr asserted at bc=40 with level=3 -> ws=0, dout=0, level=0 and s_ready=1 immediately. After release the first frame underruns.
